tfp2fix_stream: RTL and testbench
=================================

TFP2FIX_STREAM -- requirements
Module: tfp2fix_stream

Interface
REQ-001 SHALL have parameter TFP_WIDTH, default 8: width of the trivial float-point input word.
REQ-002 SHALL have parameter EXP_WIDTH, default 3: width of the exponent field, located in the TFP word LSBs.
REQ-003 SHALL have parameter FIX_WIDTH, default TFP_WIDTH - EXP_WIDTH + 2**EXP_WIDTH - 1: width of the fixed-point output.
REQ-004 SHALL have parameter SIGNREP, default "SIGNED": mantissa representation, "SIGNED" or "UNSIGNED".
REQ-005 SHALL have parameter PIPELINE, default 2: latency in clock cycles, 0 allowed.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port clk, input, 1 bit: clock.
REQ-008 SHALL have port sclr, input, 1 bit: synchronous flush of in-flight data.
REQ-009 SHALL have port i_valid, input, 1 bit: input word valid.
REQ-010 SHALL have port i_ready, output, 1 bit: block accepts input.
REQ-011 SHALL have port i_data, input, TFP_WIDTH bits: {mantissa, exponent}.
REQ-012 SHALL have port o_valid, output, 1 bit: output word valid.
REQ-013 SHALL have port o_ready, input, 1 bit: downstream accepts output.
REQ-014 SHALL have port o_data, output, FIX_WIDTH bits: fixed-point result.

Function
REQ-015 SHALL decode M = TFP_WIDTH - EXP_WIDTH, with mantissa = i_data[TFP_WIDTH-1:EXP_WIDTH] and exponent = i_data[EXP_WIDTH-1:0].
REQ-016 SHALL compute o_data = ext(mantissa) << exponent, truncated to FIX_WIDTH bits.
- ext is sign-extension when SIGNREP = "SIGNED" and zero-extension when "UNSIGNED".
- Vacated LSBs are 0, except as modified by REQ-027.
REQ-017 SHALL transfer an input word only when i_valid && i_ready, and an output word only when o_valid && o_ready.
REQ-018 SHALL, for PIPELINE > 0, implement PIPELINE register stages sharing a common advance enable en = !o_valid || o_ready, with i_ready = en.
- A word accepted at cycle t appears with o_valid at cycle t + PIPELINE when o_ready is held high.
- Bubbles do not collapse.
REQ-019 SHALL keep o_data and o_valid stable while o_valid && !o_ready.
REQ-020 SHALL, with back-to-back input and o_ready held high, sustain one word per cycle with no bubbles.
REQ-021 SHALL, for PIPELINE = 0, be purely combinational: o_valid = i_valid, i_ready = o_ready, o_data per REQ-016.
REQ-022 SHALL split the shift as follows when PIPELINE >= 2:
- Stage 1: shift by the exponent's upper bits.
- Stage 2: shift by the remaining bits.
- Further stages: delay only.
REQ-023 SHALL, on sclr high at a clock edge, clear every stage-valid bit.
- sclr overrides a simultaneous input transfer, which is dropped.
- i_ready is unaffected by sclr.

Reset
REQ-024 SHALL, while rst is asserted, immediately force o_valid = 0, all stage-valid bits = 0, and all data registers = 0, so that o_data = 0.
REQ-025 SHALL, after rst deasserts, present i_ready = 1 on the first cycle.
REQ-026 SHALL discard any word in flight when rst asserts mid-operation; no partial word may appear after reset.

Configuration
REQ-027 SHALL support the macro TFP2FIX_HALF_LSB_EN.
- Defined: when exponent > 0, set vacated bit (exponent - 1) of o_data to 1 (half-LSB reconstruction, an unbiased inverse of rounding). When exponent = 0, o_data is unchanged.
- Undefined: all vacated bits are 0, exactly as in REQ-016.
- Neither latency nor handshake behaviour depends on the macro.

Verification (defaults: M = 5, FIX_WIDTH = 12, PIPELINE = 2, SIGNED, macro undefined unless stated)
REQ-028 SHALL cover: i_data = 8'h5B (mantissa 11, exponent 3), o_ready = 1 -> o_data = 12'h058 with o_valid exactly 2 cycles after acceptance.
REQ-029 SHALL cover: i_data = 8'h87 (mantissa -16, exponent 7) -> o_data = 12'h800; the same input with SIGNREP = "UNSIGNED" -> o_data = 12'h800 (16 << 7 = 2048).
REQ-030 SHALL cover: with TFP2FIX_HALF_LSB_EN defined, 8'h5B -> 12'h05C, and 8'h58 (exponent 0) -> 12'h00B.
REQ-031 SHALL cover: a 10-word burst with o_ready toggling pseudo-randomly -> all 10 words delivered in order with no loss or duplication, and o_data stable while stalled.
REQ-032 SHALL cover: two words in flight, then sclr pulsed for 1 cycle coinciding with a third i_valid -> no o_valid for any of the three words; the next input is delivered normally.
REQ-033 SHALL cover: rst asserted asynchronously mid-burst -> o_valid = 0 and o_data = 0 immediately; the first post-reset word converts correctly.

Source files
------------

// File: rtl/tfp2fix_stream.sv
// Trivial-float to fixed-point converter with a valid/ready stream pipeline.
// Optional macro TFP2FIX_HALF_LSB_EN sets the top vacated bit (half-LSB reconstruction).
module tfp2fix_stream #(
  parameter int TFP_WIDTH = 8,
  parameter int EXP_WIDTH = 3,
  parameter int FIX_WIDTH = TFP_WIDTH - EXP_WIDTH + 2**EXP_WIDTH - 1,
  parameter     SIGNREP   = "SIGNED",
  parameter int PIPELINE  = 2
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [TFP_WIDTH-1:0] i_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [FIX_WIDTH-1:0] o_data
);

  localparam int M = TFP_WIDTH - EXP_WIDTH;
  localparam int LO_W = (EXP_WIDTH + 1) / 2;
  localparam logic [EXP_WIDTH-1:0] LO_MASK = EXP_WIDTH'((1 << LO_W) - 1);
  localparam bit SGN = (SIGNREP == "SIGNED");

  logic [M-1:0]         mant;
  logic [EXP_WIDTH-1:0] expo;
  logic [FIX_WIDTH-1:0] ext;

  assign mant = i_data[TFP_WIDTH-1:EXP_WIDTH];
  assign expo = i_data[EXP_WIDTH-1:0];

  always_comb begin
    ext = {FIX_WIDTH{SGN & mant[M-1]}};
    for (int unsigned i = 0; i < M; i++) begin
      if (i < FIX_WIDTH) ext[i] = mant[i];
    end
  end

`ifdef TFP2FIX_HALF_LSB_EN
  function automatic logic [FIX_WIDTH-1:0] half_lsb(input logic [EXP_WIDTH-1:0] e);
    half_lsb = '0;
    if (e != '0) half_lsb = FIX_WIDTH'(1) << (e - EXP_WIDTH'(1));
  endfunction
`endif

  function automatic logic [FIX_WIDTH-1:0] shift_all(input logic [FIX_WIDTH-1:0] v,
                                                     input logic [EXP_WIDTH-1:0] e);
    shift_all = v << e;
`ifdef TFP2FIX_HALF_LSB_EN
    shift_all = shift_all | half_lsb(e);
`endif
  endfunction

  if (PIPELINE == 0) begin : g_comb
    assign i_ready = o_ready;
    assign o_valid = i_valid;
    assign o_data  = shift_all(ext, expo);
  end else begin : g_pipe
    logic                 en;
    logic [PIPELINE-1:0]  v_q;
    logic [FIX_WIDTH-1:0] d_q [PIPELINE];

    assign en      = !v_q[PIPELINE-1] || o_ready;
    assign i_ready = en;
    assign o_valid = v_q[PIPELINE-1];
    assign o_data  = d_q[PIPELINE-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= '0;
      end else if (sclr) begin
        v_q <= '0;
      end else if (en) begin
        v_q[0] <= i_valid;
        for (int unsigned k = 1; k < PIPELINE; k++) v_q[k] <= v_q[k-1];
      end
    end

    if (PIPELINE == 1) begin : g_one
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     d_q[0] <= '0;
        else if (en) d_q[0] <= shift_all(ext, expo);
      end
    end else begin : g_split
      // Stage 1 shifts by the exponent's upper bits; stage 2 finishes with the low bits.
      logic [EXP_WIDTH-1:0] e_q;
      logic [FIX_WIDTH-1:0] part_shift;
      logic [FIX_WIDTH-1:0] s2;

      assign part_shift = ext << (expo & ~LO_MASK);

      always_comb begin
        s2 = d_q[0] << (e_q & LO_MASK);
`ifdef TFP2FIX_HALF_LSB_EN
        s2 = s2 | half_lsb(e_q);
`endif
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          e_q <= '0;
          for (int unsigned k = 0; k < PIPELINE; k++) d_q[k] <= '0;
        end else if (en) begin
          d_q[0] <= part_shift;
          e_q    <= expo;
          d_q[1] <= s2;
          for (int unsigned k = 2; k < PIPELINE; k++) d_q[k] <= d_q[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_tfp2fix_stream.sv
// Directed-vector bench for tfp2fix_stream (pipelined SIGNED instance plus a combinational UNSIGNED instance).
module tb_tfp2fix_stream;

  localparam int NV = 10;

  logic        clk = 1'b0, rst = 1'b0, sclr = 1'b0, i_valid = 1'b0;
  logic        o_ready = 1'b1, u_o_ready = 1'b1;
  logic [7:0]  i_data = '0;
  logic        i_ready, o_valid, u_i_ready, u_o_valid;
  logic [11:0] o_data, u_o_data;

  always #5 clk = ~clk;

  tfp2fix_stream #(.TFP_WIDTH(8), .EXP_WIDTH(3), .SIGNREP("SIGNED"), .PIPELINE(2)) u_dut (
    .rst(rst), .clk(clk), .sclr(sclr), .i_valid(i_valid), .i_ready(i_ready),
    .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data));

  tfp2fix_stream #(.TFP_WIDTH(8), .EXP_WIDTH(3), .SIGNREP("UNSIGNED"), .PIPELINE(0)) u_dut_u (
    .rst(rst), .clk(clk), .sclr(sclr), .i_valid(i_valid), .i_ready(u_i_ready),
    .i_data(i_data), .o_valid(u_o_valid), .o_ready(u_o_ready), .o_data(u_o_data));

  logic [7:0]  vin   [NV] = '{8'h5B, 8'h87, 8'h58, 8'hFF, 8'h7C, 8'hA1, 8'h0A, 8'h3D, 8'h96, 8'hE3};
`ifdef TFP2FIX_HALF_LSB_EN
  logic [11:0] exp_s [NV] = '{12'h05C, 12'h840, 12'h00B, 12'hFC0, 12'h0F8, 12'hFE9, 12'h006, 12'h0F0, 12'hCA0, 12'hFE4};
  logic [11:0] exp_u [NV] = '{12'h05C, 12'h840, 12'h00B, 12'hFC0, 12'h0F8, 12'h029, 12'h006, 12'h0F0, 12'h4A0, 12'h0E4};
`else
  logic [11:0] exp_s [NV] = '{12'h058, 12'h800, 12'h00B, 12'hF80, 12'h0F0, 12'hFE8, 12'h004, 12'h0E0, 12'hC80, 12'hFE0};
  logic [11:0] exp_u [NV] = '{12'h058, 12'h800, 12'h00B, 12'hF80, 12'h0F0, 12'h028, 12'h004, 12'h0E0, 12'h480, 12'h0E0};
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream scoreboard, sampled on the falling edge where handshakes are stable.
  bit          mon_en = 1'b0, tog_en = 1'b0, stall_prev = 1'b0;
  logic [11:0] stall_data, exp_in;
  logic [11:0] sb_q [$];
  int          delivered = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        check("stall_valid", o_valid, 1);
        check("stall_data", o_data, stall_data);
      end
      if (o_valid && o_ready) begin
        if (sb_q.size() == 0) check("spurious_out", sb_q.size(), 1);
        else begin
          check($sformatf("burst_data%0d", delivered), o_data, sb_q.pop_front());
          delivered++;
        end
      end
      stall_prev = o_valid && !o_ready;
      stall_data = o_data;
      if (i_valid && i_ready && !sclr) sb_q.push_back(exp_in);
    end
  end

  always @(posedge clk) begin
    if (tog_en) begin
      #2 o_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_one(input int idx);
    int lat;
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = vin[idx]; u_o_ready = (idx % 2 == 0);
    #1;
    check($sformatf("u_data%0d", idx), u_o_data, exp_u[idx]);
    check("u_valid", u_o_valid, 1);
    check("u_ready", u_i_ready, u_o_ready);
    check("in_ready", i_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0; lat = 1;
    while (!o_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("latency%0d", idx), lat, 2);
    check($sformatf("data%0d", idx), o_data, exp_s[idx]);
    @(posedge clk); #1;
    check("drain", o_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit acc;
    int guard;
    #1 rst = 1'b1;
    #2;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("post_rst_ready", i_ready, 1);

    for (int i = 0; i < NV; i++) send_one(i);

    // Burst with random downstream back-pressure
    stall_prev = 1'b0; delivered = 0; mon_en = 1'b1; tog_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) begin
      i_valid = 1'b1; i_data = vin[i]; exp_in = exp_s[i];
      guard = 0;
      do begin
        @(negedge clk); acc = i_ready;
        @(posedge clk); #1; guard++;
      end while (!acc && guard < 50);
      check("accept", acc, 1);
    end
    i_valid = 1'b0; tog_en = 1'b0;
    @(posedge clk); #3 o_ready = 1'b1;
    guard = 0;
    while (sb_q.size() > 0 && guard < 50) begin
      @(posedge clk); guard++;
    end
    @(negedge clk);
    check("burst_count", delivered, NV);
    check("burst_left", sb_q.size(), 0);
    mon_en = 1'b0;

    // Flush: two words in flight, third coincides with sclr
    @(posedge clk); #1 o_ready = 1'b0; i_valid = 1'b1; i_data = vin[0];
    @(posedge clk); #1 i_data = vin[1];
    @(posedge clk); #1 i_data = vin[2]; sclr = 1'b1;
    @(posedge clk); #1 sclr = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("flush_idle", o_valid, 0);
      @(posedge clk); #1;
    end
    // sclr drops a simultaneous accepted word
    i_valid = 1'b1; i_data = vin[3]; sclr = 1'b1;
    #1 check("sclr_ready", i_ready, 1);
    @(posedge clk); #1 i_valid = 1'b0; sclr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("sclr_drop", o_valid, 0);
      @(posedge clk); #1;
    end
    send_one(4);

    // Asynchronous reset mid-burst
    @(posedge clk); #1 i_valid = 1'b1; i_data = vin[5];
    @(posedge clk); #1 i_data = vin[6];
    @(posedge clk); #1 i_data = vin[7];
    check("pre_arst_valid", o_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_data", o_data, 0);
    i_valid = 1'b0;
    @(posedge clk); #1 check("arst_hold", o_valid, 0);
    @(negedge clk) rst = 1'b0;
    #1 check("arst_ready", i_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1 check("arst_idle", o_valid, 0);
    end
    send_one(8);
    send_one(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
